// File: rtl/conv1_pkg.sv
// Shared definitions for the conv1 datapath.
// Holds the default pixel word width, kernel geometry, default image size,
// and the 9-word window type that the window generator and the filter share.
package conv1_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int KERNEL_SIZE = 3;
  localparam int WIN_SIZE    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IMG_WIDTH   = 28;
  localparam int IMG_HEIGHT  = 28;

  // Row-major window: [0] top-left ... [WIN_SIZE-1] bottom-right (newest pixel).
  // Index k pairs with filter weight[k].
  typedef logic [0:WIN_SIZE-1][DATA_WIDTH-1:0] window_t;

endpackage

// File: rtl/conv1_line_buffer.sv
// One image row of storage, indexed by column.
// Read is combinational from the pre-edge contents; the write lands on the
// same edge, so a read and a write to one column in one cycle return the old
// word (read-before-write). Contents are deliberately not reset.
// Ports:
//   clk      clock
//   we_i     write enable
//   addr_i   column index (read and write)
//   wdata_i  word to store at addr_i
//   rdata_o  word currently stored at addr_i
module conv1_line_buffer #(
  parameter int DEPTH  = 28,
  parameter int DW     = 32,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DW-1:0]     wdata_i,
  output logic [DW-1:0]     rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/conv1_window_gen.sv
// Streaming 3x3 window generator for the conv1 filter.
// Takes one raster-order pixel per valid cycle, keeps the two previous rows
// in line buffers, and emits a registered window for every valid-convolution
// position (no padding, stride 1). Pixel bits pass through untouched.
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   valid_in    pixel_in is valid this cycle
//   pixel_in    raster-order pixel
//   data_out    window, row-major, [0]=top-left, [8]=newest pixel
//   valid_out   data_out holds a complete window (one cycle per window)
//   frame_done  pulses with the last window of a frame
module conv1_window_gen #(
  parameter int DATA_WIDTH = conv1_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH  = conv1_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = conv1_pkg::IMG_HEIGHT
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        valid_in,
  input  logic [DATA_WIDTH-1:0]                       pixel_in,
  output logic [0:conv1_pkg::WIN_SIZE-1][DATA_WIDTH-1:0] data_out,
  output logic                                        valid_out,
  output logic                                        frame_done
);
  import conv1_pkg::*;

  localparam int K     = KERNEL_SIZE;
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [0:WIN_SIZE-1][DATA_WIDTH-1:0] w_q, w_d;
  logic valid_q, valid_d;
  logic done_q,  done_d;
  logic [DATA_WIDTH-1:0] top_rd, mid_rd;
  logic last_col, last_row, win_pos;

  // Row r-2: refilled from row r-1 as row r-1 is overwritten by the new pixel.
  conv1_line_buffer #(.DEPTH(IMG_WIDTH), .DW(DATA_WIDTH), .ADDR_W(COL_W)) u_lb_top (
    .clk     (clk),
    .we_i    (valid_in),
    .addr_i  (col_q),
    .wdata_i (mid_rd),
    .rdata_o (top_rd)
  );

  // Row r-1.
  conv1_line_buffer #(.DEPTH(IMG_WIDTH), .DW(DATA_WIDTH), .ADDR_W(COL_W)) u_lb_mid (
    .clk     (clk),
    .we_i    (valid_in),
    .addr_i  (col_q),
    .wdata_i (pixel_in),
    .rdata_o (mid_rd)
  );

  assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
  // Only positions with two full rows and two full columns behind them form
  // a window. The first two columns after a row wrap hold mixed-row data in
  // w_q and must stay suppressed.
  assign win_pos  = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // Shift left one column, then load the new right column.
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          w_d[r*K + c] = w_q[r*K + c + 1];
        end
      end
      w_d[K-1]      = top_rd;
      w_d[2*K-1]    = mid_rd;
      w_d[K*K-1]    = pixel_in;
      valid_d       = win_pos;
      done_d        = last_row && last_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data_out   = w_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_conv1_window_gen.sv
module tb_conv1_window_gen;
  import conv1_pkg::*;

  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic [31:0] pixel_in = '0;
  window_t data_out;
  logic valid_out, frame_done;

  conv1_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .pixel_in   (pixel_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { window_t win; logic fd; } exp_t;
  exp_t    exp_q[$];
  window_t got_q[$];
  window_t stream_q[$];
  logic [31:0] img [0:H-1][0:W-1];
  int r_m = 0, c_m = 0;
  int tests = 0, fails = 0;
  int fd_cnt = 0;
  logic vin_last = 1'b0;
  logic chk_hold = 1'b0;
  window_t prev_out = '0;

  // Scoreboard expectation built from the stored image, not from a shift model.
  task automatic drive(input logic [31:0] p);
    exp_t e;
    valid_in = 1'b1;
    pixel_in = p;
    img[r_m][c_m] = p;
    if (r_m >= 2 && c_m >= 2) begin
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          e.win[dr*3 + dc] = img[r_m-2+dr][c_m-2+dc];
      e.fd = (r_m == H-1) && (c_m == W-1);
      exp_q.push_back(e);
    end
    c_m++;
    if (c_m == W) begin
      c_m = 0;
      r_m++;
      if (r_m == H) r_m = 0;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_win(input string tag, input window_t got, input window_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic new_phase();
    got_q.delete();
    fd_cnt = 0;
  endtask

  always @(posedge clk) vin_last = valid_in;

  always @(negedge clk) begin
    if (valid_out) begin
      exp_t e;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_window got=%h exp=none", data_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_win("window", data_out, e.win);
        tests++;
        assert (frame_done === e.fd) else begin
          fails++;
          $error("FAIL frame_done got=%b exp=%b", frame_done, e.fd);
        end
      end
      tests++;
      assert (vin_last === 1'b1) else begin
        fails++;
        $error("FAIL valid_after_idle got=1 exp=0");
      end
      got_q.push_back(data_out);
      if (frame_done) fd_cnt++;
    end else begin
      tests++;
      assert (frame_done === 1'b0) else begin
        fails++;
        $error("FAIL done_without_valid got=%b exp=0", frame_done);
      end
      if (chk_hold && !vin_last) check_win("hold_in_gap", data_out, prev_out);
    end
    prev_out = data_out;
  end

  initial begin
    window_t w_first, w_last, w_wrap, w_f2;
    w_first = '{32'd0, 32'd1, 32'd2, 32'd5, 32'd6, 32'd7, 32'd10, 32'd11, 32'd12};
    w_last  = '{32'd7, 32'd8, 32'd9, 32'd12, 32'd13, 32'd14, 32'd17, 32'd18, 32'd19};
    w_wrap  = '{32'd5, 32'd6, 32'd7, 32'd10, 32'd11, 32'd12, 32'd15, 32'd16, 32'd17};
    w_f2    = '{32'd20, 32'd21, 32'd22, 32'd25, 32'd26, 32'd27, 32'd30, 32'd31, 32'd32};

    // Reset state
    #12;
    check_win("reset_data", data_out, '0);
    check_int("reset_valid", int'(valid_out), 0);
    check_int("reset_done", int'(frame_done), 0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // Streaming frame
    new_phase();
    for (int i = 0; i < 20; i++) drive(i);
    idle(3);
    check_int("stream_count", got_q.size(), 6);
    check_int("stream_fd_count", fd_cnt, 1);
    if (got_q.size() == 6) begin
      check_win("stream_first", got_q[0], w_first);
      check_win("stream_rowwrap", got_q[3], w_wrap);
      check_win("stream_last", got_q[5], w_last);
    end
    stream_q = got_q;

    // Bubbles: 1,0,0,1,... pattern
    new_phase();
    chk_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin drive(i); idle(2); end
    idle(2);
    chk_hold = 1'b0;
    check_int("bubble_count", got_q.size(), 6);
    check_int("bubble_fd_count", fd_cnt, 1);
    if (got_q.size() == 6 && stream_q.size() == 6)
      for (int k = 0; k < 6; k++) check_win("bubble_vs_stream", got_q[k], stream_q[k]);

    // Back-to-back frames
    new_phase();
    for (int i = 0; i < 40; i++) drive(i);
    idle(3);
    check_int("b2b_count", got_q.size(), 12);
    check_int("b2b_fd_count", fd_cnt, 2);
    if (got_q.size() == 12) check_win("b2b_frame2_first", got_q[6], w_f2);

    // Reset mid-frame after pixel 13
    new_phase();
    for (int i = 0; i < 14; i++) drive(i);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_win("midrst_data", data_out, '0);
    check_int("midrst_valid", int'(valid_out), 0);
    check_int("midrst_done", int'(frame_done), 0);
    check_int("midrst_pending", exp_q.size(), 0);
    exp_q.delete();
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    r_m = 0; c_m = 0;
    new_phase();
    idle(1);
    for (int i = 0; i < 20; i++) drive(i);
    idle(3);
    check_int("midrst_count", got_q.size(), 6);
    check_int("midrst_fd_count", fd_cnt, 1);
    if (got_q.size() == 6) begin
      check_win("midrst_first", got_q[0], w_first);
      check_win("midrst_last", got_q[5], w_last);
    end

    // FP passthrough: NaN and denormal
    new_phase();
    for (int i = 0; i < 20; i++) begin
      if (i == 11)      drive(32'h0000_0001);
      else if (i == 12) drive(32'h7FC0_0000);
      else              drive(i);
    end
    idle(3);
    check_int("fp_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      check_int("fp_nan", int'(got_q[0][8]), int'(32'h7FC0_0000));
      check_int("fp_denorm", int'(got_q[0][7]), 1);
    end
    check_int("final_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv1_window_gen.md
Name: conv1_window_gen

Overview:
- Streaming 3x3 window generator that feeds the conv1 filter datapath.
- Accepts one 32-bit IEEE-754 pixel per valid cycle in raster order and buffers the two previous image rows.
- Emits a registered 9-word window (data_out[0:8]) plus valid_out for every "valid"-convolution position, with no padding and stride 1.
- Window layout matches the filter's weight indexing, so data_out[k] pairs with weight[k].

Parameters:
- DATA_WIDTH, 32, pixel word width (fp32 bit pattern, passed through untouched)
- IMG_WIDTH, 28, pixels per row
- IMG_HEIGHT, 28, rows per frame

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  pixel_in is valid this cycle (no backpressure; source may insert idle cycles)
- pixel_in  input  DATA_WIDTH  raster-order pixel
- data_out  output  DATA_WIDTH x [0:8]  window, row-major; [0]=top-left, [8]=bottom-right (newest pixel)
- valid_out  output  1  data_out holds a complete window
- frame_done  output  1  one-cycle pulse, coincident with the last window of a frame

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n). Reset is fixed in polarity and synchronicity.
- Reset values: data_out all 0, valid_out 0, frame_done 0, col=0, row=0.
- Line buffer contents are not reset; stale contents never reach a valid window.
- Counters: col in 0..IMG_WIDTH-1, row in 0..IMG_HEIGHT-1, both advance only on valid_in.
  - col wraps to 0 and increments row.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0. The next pixel starts a new frame with no idle cycle required.
- Storage:
  - lb_top[IMG_WIDTH] holds row r-2; lb_mid[IMG_WIDTH] holds row r-1.
  - A 3x3 register window w[0:8] holds the current window.
- On an accepted pixel p at (row, col), registered in the same edge:
  - The window shifts left one column: w[0]<=w[1], w[1]<=w[2], w[3]<=w[4], w[4]<=w[5], w[6]<=w[7], w[7]<=w[8].
  - The new right column is w[2]<=lb_top[col], w[5]<=lb_mid[col], w[8]<=p.
  - lb_top[col]<=lb_mid[col]; lb_mid[col]<=p. Reads use the pre-edge values.
- Output and latency:
  - data_out is w directly.
  - valid_out<=1 on the edge accepting a pixel with row>=2 and col>=2; otherwise valid_out<=0.
  - Latency is 1 cycle from the accepted pixel to the window on data_out.
- Idle cycles (valid_in=0): w and counters hold; valid_out<=0; frame_done<=0. No window is ever repeated.
- frame_done<=1 exactly when the accepted pixel is at (IMG_HEIGHT-1, IMG_WIDTH-1), alongside valid_out=1.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2); 676 at the defaults.
- Rows 0-1 and columns 0-1 of every row produce no output. This includes the first two columns after a row wrap, even though w holds mixed-row data there.
- Reset mid-frame: all outputs clear immediately (asynchronously). The next accepted pixel is treated as (0,0); no partial window from the aborted frame is emitted.
- Arithmetic: none on pixel data; bits pass through unchanged, including NaN and denormal patterns.

Decomposition:
- Shared package conv1_pkg holds:
  - DATA_WIDTH=32, KERNEL_SIZE=3, IMG_WIDTH/IMG_HEIGHT defaults
  - a typedef for a 9-word window array, shared with the filter
- One sub-module, conv1_line_buffer:
  - IMG_WIDTH-deep, DATA_WIDTH-wide, column-indexed read-before-write memory
  - instantiated twice, for the top and mid rows

Test Plan:
- Bench uses IMG_WIDTH=5, IMG_HEIGHT=4, pixels 0..19 as raw integers.
- Streaming frame, valid_in held high for 20 cycles:
  - Exactly 6 valid_out pulses.
  - First window, one cycle after pixel 12 = {0,1,2,5,6,7,10,11,12}.
  - Last window = {7,8,9,12,13,14,17,18,19}, with frame_done=1 on that cycle only.
- Row-wrap suppression: no valid_out for pixels 15 and 16. The window after pixel 17 = {5,6,7,10,11,12,15,16,17}.
- Bubbles: same stream with valid_in toggling 1,0,0,1,...
  - Identical 6 windows in the same order.
  - valid_out never high on a cycle that follows an idle input cycle.
  - data_out holds during gaps.
- Back-to-back frames: pixels 0..39 continuous.
  - 12 windows total.
  - Frame-2 first window = {20,21,22,25,26,27,30,31,32}.
  - frame_done pulses after pixels 19 and 39.
- Reset mid-frame: assert rst_n=0 after pixel 13, then restart at 0..19.
  - Outputs go to 0 during reset.
  - Results then match the streaming-frame case exactly: 6 windows, first = {0,1,2,5,6,7,10,11,12}.
- FP passthrough:
  - Pixel 12 = 32'h7FC00000 (NaN) and pixel 11 = 32'h00000001 (denormal).
  - data_out[8]=32'h7FC00000 and data_out[7]=32'h00000001 in the first window, bit-exact.
